// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared definitions for the load/store unit: RV32 load/store
//               funct3 encodings, FSM state type and default memory size.
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

    localparam int LSU_MEM_BYTES = 1024;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LD_RD  = 3'd1,
        S_ST_WR  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5
    } lsu_state_t;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Combinational lane logic for the load/store unit.
//               Load path : pick byte/half at the byte offset of a read word
//                           and sign/zero extend it according to funct3.
//               Store path: merge a byte/half of store data into a word
//                           (full word replacement for SW).
// Ports       : i_rd_word     - word read from memory (load path)
//               i_offset      - byte offset ADDR[1:0]
//               i_funct3      - RV32 load/store funct3
//               i_merge_word  - previously read word (store path)
//               i_store_data  - rs2 value
//               o_load_data   - extended load result
//               o_merged_word - word to write back
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] i_rd_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_merge_word,
    input  logic [31:0] i_store_data,
    output logic [31:0] o_load_data,
    output logic [31:0] o_merged_word
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_byte_en;
    logic [31:0] w_lane_data;

    // Halfwords are naturally aligned, so only ADDR[1] selects the half.
    assign w_byte = i_rd_word[{i_offset, 3'b000} +: 8];
    assign w_half = i_rd_word[{i_offset[1], 4'b0000} +: 16];

    always_comb begin
        o_load_data = i_rd_word;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_BU:   o_load_data = {24'h000000, w_byte};
            F3_HU:   o_load_data = {16'h0000, w_half};
            default: o_load_data = i_rd_word;
        endcase
    end

    // Store data is replicated across all lanes; the byte enables pick which
    // lanes take it and which keep the old memory contents.
    always_comb begin
        w_byte_en   = 4'b1111;
        w_lane_data = i_store_data;
        case (i_funct3)
            F3_B: begin
                w_byte_en   = 4'b0001 << i_offset;
                w_lane_data = {4{i_store_data[7:0]}};
            end
            F3_H: begin
                w_byte_en   = i_offset[1] ? 4'b1100 : 4'b0011;
                w_lane_data = {2{i_store_data[15:0]}};
            end
            default: begin
                w_byte_en   = 4'b1111;
                w_lane_data = i_store_data;
            end
        endcase
    end

    for (genvar k = 0; k < 4; k++) begin : g_lane
        assign o_merged_word[8*k +: 8] = w_byte_en[k] ? w_lane_data[8*k +: 8]
                                                      : i_merge_word[8*k +: 8];
    end

endmodule : lsu_align
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module      : load_store_unit
// Description : MEM-stage initiator for the byte-addressed data memory.
//               Executes one load/store per request, extends load data,
//               performs SB/SH as read-modify-write on a word-only memory,
//               stalls the pipeline while busy and reports access faults.
// Ports       : CLK, RESET (async, active-high)
//               REQ_READ/REQ_WRITE/FUNCT3/ADDR/STORE_DATA - pipeline request
//               LOAD_DATA, STALL, DONE, ACCESS_FAULT      - pipeline response
//               DM_READ/DM_WRITE/DM_ADDRESS/DM_WRITEDATA  - memory command
//               DM_READDATA                               - memory read data
// Revision    : 1.0 - initial release
// ============================================================================
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int MEM_BYTES   = LSU_MEM_BYTES,
    parameter int CHECK_RANGE = 1
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ_READ,
    input  logic        REQ_WRITE,
    input  logic [2:0]  FUNCT3,
    input  logic [31:0] ADDR,
    input  logic [31:0] STORE_DATA,
    output logic [31:0] LOAD_DATA,
    output logic        STALL,
    output logic        DONE,
    output logic        ACCESS_FAULT,
    output logic        DM_READ,
    output logic        DM_WRITE,
    output logic [31:0] DM_ADDRESS,
    output logic [31:0] DM_WRITEDATA,
    input  logic [31:0] DM_READDATA
);

    localparam logic [31:0] C_MAX_WORD_ADDR = 32'(MEM_BYTES - 4);

    lsu_state_t  r_state;
    lsu_state_t  w_next_state;

    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_store_data;
    logic [31:0] r_merge;
    logic [31:0] r_load_data;
    logic        r_fault;

    logic        w_req;
    logic        w_is_store;
    logic        w_illegal;
    logic        w_misaligned;
    logic        w_out_of_range;
    logic        w_fault;
    logic [31:0] w_load_ext;
    logic [31:0] w_merged;

    // A store request takes priority over a simultaneous load request.
    assign w_req      = REQ_READ | REQ_WRITE;
    assign w_is_store = REQ_WRITE;

    // ---------------------------------------------------------------------
    // Fault decode on the incoming request
    // ---------------------------------------------------------------------
    always_comb begin
        w_illegal      = 1'b0;
        w_misaligned   = 1'b0;
        w_out_of_range = 1'b0;
        if (w_is_store) begin
            w_illegal = !((FUNCT3 == F3_B) || (FUNCT3 == F3_H) || (FUNCT3 == F3_W));
        end else begin
            w_illegal = (FUNCT3 == 3'b011) || (FUNCT3 == 3'b110) || (FUNCT3 == 3'b111);
        end
        case (FUNCT3[1:0])
            2'b01:   w_misaligned = ADDR[0];
            2'b10:   w_misaligned = (ADDR[1:0] != 2'b00);
            default: w_misaligned = 1'b0;
        endcase
        if (CHECK_RANGE != 0) begin
            w_out_of_range = ({ADDR[31:2], 2'b00} > C_MAX_WORD_ADDR);
        end
        w_fault = w_illegal | w_misaligned | w_out_of_range;
    end

    // ---------------------------------------------------------------------
    // Lane extraction / merge
    // ---------------------------------------------------------------------
    lsu_align u_align (
        .i_rd_word     (DM_READDATA),
        .i_offset      (r_addr[1:0]),
        .i_funct3      (r_funct3),
        .i_merge_word  (r_merge),
        .i_store_data  (r_store_data),
        .o_load_data   (w_load_ext),
        .o_merged_word (w_merged)
    );

    // ---------------------------------------------------------------------
    // FSM state register
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ---------------------------------------------------------------------
    // FSM next-state and output decode
    // ---------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        DM_READ      = 1'b0;
        DM_WRITE     = 1'b0;
        DM_WRITEDATA = 32'h0;
        DONE         = 1'b0;
        ACCESS_FAULT = 1'b0;
        STALL        = 1'b0;
        case (r_state)
            S_IDLE: begin
                STALL = w_req;
                if (w_req) begin
                    if (w_fault) begin
                        w_next_state = S_RESP;
                    end else if (!w_is_store) begin
                        w_next_state = S_LD_RD;
                    end else if (FUNCT3 == F3_W) begin
                        w_next_state = S_ST_WR;
                    end else begin
                        w_next_state = S_RMW_RD;
                    end
                end
            end
            S_LD_RD: begin
                STALL        = 1'b1;
                DM_READ      = 1'b1;
                w_next_state = S_RESP;
            end
            S_ST_WR: begin
                STALL        = 1'b1;
                DM_WRITE     = 1'b1;
                DM_WRITEDATA = r_store_data;
                w_next_state = S_RESP;
            end
            S_RMW_RD: begin
                STALL        = 1'b1;
                DM_READ      = 1'b1;
                w_next_state = S_RMW_WR;
            end
            S_RMW_WR: begin
                STALL        = 1'b1;
                DM_WRITE     = 1'b1;
                DM_WRITEDATA = w_merged;
                w_next_state = S_RESP;
            end
            S_RESP: begin
                // The pipeline advances in this cycle, so no stall here.
                DONE         = 1'b1;
                ACCESS_FAULT = r_fault;
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // Datapath capture registers
    // ---------------------------------------------------------------------
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_funct3     <= 3'b000;
            r_addr       <= 32'h0;
            r_store_data <= 32'h0;
            r_merge      <= 32'h0;
            r_load_data  <= 32'h0;
            r_fault      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_funct3     <= FUNCT3;
                        r_addr       <= ADDR;
                        r_store_data <= STORE_DATA;
                        r_fault      <= w_fault;
                    end
                end
                S_LD_RD:  r_load_data <= w_load_ext;
                S_RMW_RD: r_merge     <= DM_READDATA;
                default: ;
            endcase
        end
    end

    assign DM_ADDRESS = {r_addr[31:2], 2'b00};
    assign LOAD_DATA  = r_load_data;

endmodule : load_store_unit
`default_nettype wire

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
MEM-stage initiator for the byte-addressed data memory in the RV32IM pipeline. Accepts one load/store per request from the pipeline and drives the memory's READ/WRITE/ADDRESS/WRITEDATA port. Performs sub-word extraction and sign/zero extension for loads. Memory writes are full-word only, so SB/SH are done as read-modify-write. Stalls the pipeline while busy and flags faults (misaligned, illegal funct3, out of range).

Parameters:
MEM_BYTES, 1024, data memory size in bytes; valid word addresses are 0..MEM_BYTES-4.
CHECK_RANGE, 1, when 1, an out-of-range address raises ACCESS_FAULT.

Ports:
CLK  in  1  clock, posedge.
RESET  in  1  asynchronous, active-high reset.
REQ_READ  in  1  load request; held by the pipeline until DONE.
REQ_WRITE  in  1  store request; held until DONE.
FUNCT3  in  3  RV32 load/store funct3.
ADDR  in  32  effective byte address.
STORE_DATA  in  32  rs2 value.
LOAD_DATA  out  32  extended load result; registered, valid from DONE.
STALL  out  1  freeze upstream stages.
DONE  out  1  one-cycle completion pulse.
ACCESS_FAULT  out  1  one-cycle, coincident with DONE.
DM_READ  out  1  memory read enable.
DM_WRITE  out  1  memory write enable; the write commits on the CLK edge.
DM_ADDRESS  out  32  always word-aligned: {ADDR[31:2],2'b00}.
DM_WRITEDATA  out  32  full word to write.
DM_READDATA  in  32  combinational read data; lane k = byte at DM_ADDRESS+k (little-endian).

Behaviour:
- Reset (async): state IDLE; LOAD_DATA=0; DONE, ACCESS_FAULT, DM_READ, DM_WRITE=0; DM_ADDRESS, DM_WRITEDATA=0; internal capture registers=0.
- DM_* outputs and STALL are decoded from state and registers only. They go inactive immediately on RESET.
- States: IDLE, LD_RD, ST_WR, RMW_RD, RMW_WR, RESP.
- Request priority: REQ_WRITE=1 means a store and REQ_READ is ignored; REQ_READ=1 alone means a load.
- IDLE, request present, on the CLK edge:
  - Capture op, FUNCT3, ADDR, STORE_DATA.
  - Fault check:
    - Misaligned: half with ADDR[0]=1; word with ADDR[1:0]!=0.
    - Illegal funct3: loads 011/110/111; stores other than 000/001/010.
    - Range: CHECK_RANGE=1 and aligned address > MEM_BYTES-4.
  - Fault goes to RESP with the fault latched. Otherwise: load goes to LD_RD; SW goes to ST_WR; SB/SH go to RMW_RD.
- LD_RD: DM_READ=1. On the edge, extract the byte/half at lane ADDR[1:0] (half uses lanes ADDR[1]*2 and +1). Extend per funct3 (LB/LH sign, LBU/LHU zero, LW whole) into LOAD_DATA. Go to RESP.
- ST_WR: DM_WRITE=1, DM_WRITEDATA=STORE_DATA. Go to RESP.
- RMW_RD: DM_READ=1. Capture DM_READDATA into the merge register. Go to RMW_WR.
- RMW_WR: DM_WRITE=1. DM_WRITEDATA = merge word with the target lane(s) replaced by STORE_DATA[7:0] (SB) or [15:0] (SH). Go to RESP.
- RESP: DONE=1, ACCESS_FAULT=latched fault. Go to IDLE unconditionally. The pipeline advances this cycle, so a new request is accepted one cycle after RESP.
- STALL = (IDLE & request present) | state in {LD_RD, ST_WR, RMW_RD, RMW_WR}. STALL=0 in RESP.
- Latency, request seen in IDLE to DONE: load 3 cycles, SW 3, SB/SH 4, fault 2.
- Fault: no DM_READ/DM_WRITE is asserted and LOAD_DATA is unchanged.
- Request dropped mid-operation: ignored; the operation completes.
- Reset mid-RMW: if RESET rises before the RMW_WR edge, no write occurs and memory is unchanged.
- LOAD_DATA holds its value until the next completed load.

Decomposition:
- Shared package lsu_pkg holds:
  - funct3 constants F3_B=000, F3_H=001, F3_W=010, F3_BU=100, F3_HU=101.
  - The state enum.
  - MEM_BYTES default.
- One combinational sub-module, lsu_align:
  - load path: (word, offset, funct3) to extended data.
  - store path: (word, offset, funct3, data) to merged word.

Test Plan:
1. Preload bytes 0x100..0x103 = BB,AA,99,88. LW 0x100 -> LOAD_DATA=0x8899AABB, DONE 3 cycles after request, STALL high 2 cycles, DM_READ only in LD_RD.
2. Same preload:
   - LB 0x103 -> 0xFFFFFF88
   - LBU 0x103 -> 0x00000088
   - LH 0x102 -> 0xFFFF8899
   - LHU 0x100 -> 0x0000AABB
3. SB 0x101 with STORE_DATA=0x12345677 -> RMW_WR drives DM_ADDRESS=0x100, DM_WRITEDATA=0x889977BB; DONE at cycle 4; a following LW 0x100 returns 0x889977BB.
4. Faults:
   - SH 0x101 -> ACCESS_FAULT=1 with DONE at cycle 2, no DM_WRITE, memory unchanged.
   - LW 0x102 -> fault.
   - LW 0x400 with MEM_BYTES=1024 -> fault.
   - Load funct3=011 -> fault.
5. SB 0x101 with RESET pulsed during RMW_RD -> DM_WRITE never asserts, outputs reset, bytes 0x100..0x103 unchanged.
6. Back-to-back SW 0x200 0xDEADBEEF then LW 0x200 -> LOAD_DATA=0xDEADBEEF; second request accepted the cycle after the first DONE.
